if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port jmp_en  in  1  redirect request from branch/jump resolution, single-cycle pulse.
REQ-004 SHALL have port jmp_addr  in  64  redirect target; bits [1:0] ignored and treated as 0.
REQ-005 SHALL have port if_req  out  1  fetch request valid to instruction memory.
REQ-006 SHALL have port if_addr  out  64  fetch address, 4-byte aligned.
REQ-007 SHALL have port if_ready  in  1  memory accepts request; handshake when if_req & if_ready.
REQ-008 SHALL have port if_rvalid  in  1  response valid, one cycle, at most one per accepted request, in order.
REQ-009 SHALL have port if_rdata  in  32  fetched instruction word.
REQ-010 SHALL have port id_valid  out  1  instruction buffer holds a valid instruction for decode.
REQ-011 SHALL have port id_inst  out  32  instruction to decode stage.
REQ-012 SHALL have port id_inst_addr  out  64  address of id_inst.
REQ-013 SHALL have port id_ready  in  1  decode consumes; transfer when id_valid & id_ready.
REQ-014 SHALL have parameter RESET_PC, default 64'h0000_0000_8000_0000, first fetch address.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, WAIT; IDLE -> REQ unconditionally one cycle after reset release.
REQ-016 SHALL hold registers pc (next fetch address), req_addr (address of outstanding request), kill (discard flag), and a one-entry instruction buffer (id_valid/id_inst/id_inst_addr).
REQ-017 SHALL assert if_req only in REQ and only when buffer empty or draining this cycle (id_valid=0 or id_ready=1); if_addr = pc.
REQ-018 SHALL, on request handshake: req_addr <= pc, pc <= pc+4 (modulo 2^64, wraps to 0), state -> WAIT.
REQ-019 SHALL, in WAIT with if_rvalid and kill=0: load buffer with if_rdata/req_addr, id_valid <= 1, state -> REQ.
REQ-020 SHALL, in WAIT with if_rvalid and kill=1: drop response, clear kill, state -> REQ, buffer unchanged.
REQ-021 SHALL clear id_valid on transfer unless a new response loads the buffer in the same cycle (load wins).
REQ-022 SHALL guarantee at most one outstanding memory request and never overwrite an unconsumed buffer entry.
REQ-023 SHALL, on jmp_en: pc <= {jmp_addr[63:2],2'b00}, id_valid <= 0 (flush), overriding any pc+4 update that cycle.
REQ-024 SHALL, on jmp_en in WAIT without if_rvalid, or in REQ coinciding with request handshake: set kill <= 1.
REQ-025 SHALL, on jmp_en in WAIT coinciding with if_rvalid: drop that response, kill stays 0, state -> REQ.
REQ-026 SHALL, on jmp_en in REQ without handshake: next if_addr = redirect target (address may change while if_req held, no acceptance pending).
REQ-027 SHALL, on jmp_en coinciding with an id transfer: transfer completes as seen by decode, buffer ends empty.
REQ-028 SHALL ignore if_rvalid in IDLE and REQ.

Reset
REQ-029 SHALL, while rst=1: pc=RESET_PC, req_addr=0, kill=0, state=IDLE, if_req=0, if_addr=RESET_PC, id_valid=0, id_inst=0, id_inst_addr=0.
REQ-030 SHALL, on rst asserted mid-operation, abandon any outstanding request; responses to it arriving after release in IDLE/REQ are ignored.

Verification
REQ-031 Reset release, if_ready=1, rvalid 1 cycle later with 32'h00000513 -> if_addr 0x80000000, id_valid=1, id_inst=0x00000513, id_inst_addr=0x80000000; next if_addr 0x80000004.
REQ-032 id_ready=0 held, memory always ready -> exactly one instruction buffered, if_req=0 until id_ready=1, no loss or duplicate.
REQ-033 jmp_en, jmp_addr=0x80000103 while WAIT -> late response dropped, next if_addr 0x80000100, id_valid=0 until its response.
REQ-034 jmp_en coincident with if_rvalid -> response dropped, buffer empty, next if_addr = target.
REQ-035 pc=64'hFFFF_FFFF_FFFF_FFFC fetch accepted -> next if_addr 0.
REQ-036 rst pulsed while WAIT, stale if_rvalid after release -> ignored, first fetch at RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: a three-state fetch FSM issuing one request at a
// time to instruction memory, a one-entry instruction buffer facing decode,
// and redirect handling that discards responses belonging to stale fetches.
module if_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jmp_en,
  input  logic [63:0] jmp_addr,
  output logic        if_req,
  output logic [63:0] if_addr,
  input  logic        if_ready,
  input  logic        if_rvalid,
  input  logic [31:0] if_rdata,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [63:0] id_inst_addr,
  input  logic        id_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] req_addr_q, req_addr_d;
  logic        kill_q, kill_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [63:0] id_inst_addr_q, id_inst_addr_d;

  logic        if_req_s;
  logic        hs_s;
  logic        xfer_s;
  logic        load_s;
  logic [63:0] jmp_tgt_s;
  logic        unused_jmp_low_s;

  // The two low target bits are architecturally ignored.
  assign jmp_tgt_s        = {jmp_addr[63:2], 2'b00};
  assign unused_jmp_low_s = ^jmp_addr[1:0];

  // Request only when the buffer is free (or being drained this cycle), so a
  // returning word can never overwrite an unconsumed instruction.
  assign if_req_s = (state_q == REQ) && (!id_valid_q || id_ready);
  assign hs_s     = if_req_s && if_ready;
  assign xfer_s   = id_valid_q && id_ready;

  assign if_req       = if_req_s;
  assign if_addr      = pc_q;
  assign id_valid     = id_valid_q;
  assign id_inst      = id_inst_q;
  assign id_inst_addr = id_inst_addr_q;

  // Next-state, fetch bookkeeping and instruction buffer update.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    req_addr_d     = req_addr_q;
    kill_d         = kill_q;
    id_valid_d     = id_valid_q;
    id_inst_d      = id_inst_q;
    id_inst_addr_d = id_inst_addr_q;
    load_s         = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        if (hs_s) begin
          req_addr_d = pc_q;
          pc_d       = pc_q + 64'd4;
          state_d    = WAIT;
          // A redirect in the acceptance cycle makes this fetch stale.
          if (jmp_en) begin
            kill_d = 1'b1;
          end else begin
            kill_d = kill_q;
          end
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (if_rvalid) begin
          state_d = REQ;
          kill_d  = 1'b0;
          // Keep the word only if no redirect has made it stale.
          if (!kill_q && !jmp_en) begin
            load_s = 1'b1;
          end else begin
            load_s = 1'b0;
          end
        end else if (jmp_en) begin
          kill_d = 1'b1;
        end else begin
          kill_d = kill_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new load takes priority over clearing on transfer.
    if (load_s) begin
      id_valid_d     = 1'b1;
      id_inst_d      = if_rdata;
      id_inst_addr_d = req_addr_q;
    end else if (xfer_s) begin
      id_valid_d = 1'b0;
    end else begin
      id_valid_d = id_valid_q;
    end

    // Redirect overrides sequential pc advance and flushes the buffer.
    if (jmp_en) begin
      pc_d       = jmp_tgt_s;
      id_valid_d = 1'b0;
    end else begin
      pc_d = pc_d;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      pc_q           <= RESET_PC;
      req_addr_q     <= 64'd0;
      kill_q         <= 1'b0;
      id_valid_q     <= 1'b0;
      id_inst_q      <= 32'd0;
      id_inst_addr_q <= 64'd0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      req_addr_q     <= req_addr_d;
      kill_q         <= kill_d;
      id_valid_q     <= id_valid_d;
      id_inst_q      <= id_inst_d;
      id_inst_addr_q <= id_inst_addr_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: inputs change on the falling edge, outputs are
// sampled 1 time unit later, well away from the rising edge.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jmp_en = 1'b0;
  logic [63:0] jmp_addr = 64'd0;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_ready = 1'b0;
  logic        if_rvalid = 1'b0;
  logic [31:0] if_rdata = 32'd0;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [63:0] id_inst_addr;
  logic        id_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  if_stage #(.RESET_PC(64'h0000_0000_8000_0000)) dut (
    .clk(clk), .rst(rst), .jmp_en(jmp_en), .jmp_addr(jmp_addr),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .id_valid(id_valid), .id_inst(id_inst), .id_inst_addr(id_inst_addr),
    .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  // Advance one full cycle, ending at the falling edge.
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold reset, release it and wait for the IDLE->REQ transition.
  task automatic do_reset;
    rst = 1'b1; jmp_en = 1'b0; jmp_addr = 64'd0; if_ready = 1'b0;
    if_rvalid = 1'b0; if_rdata = 32'd0; id_ready = 1'b0;
    step; step;
    rst = 1'b0;
    step;
  endtask

  // From REQ with if_ready=1: accept a request, then return one word.
  task automatic fetch_one(input logic [31:0] word);
    step;
    if_rvalid = 1'b1; if_rdata = word;
    step;
    if_rvalid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step; step; #1;
    checks++; if (if_req !== 1'b0) begin errors++; $display("FAIL rst_if_req: got %b want 0", if_req); end
    checks++; if (if_addr !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL rst_if_addr: got %h want 80000000", if_addr); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_id_valid: got %b want 0", id_valid); end
    checks++; if (id_inst !== 32'd0) begin errors++; $display("FAIL rst_id_inst: got %h want 0", id_inst); end
    checks++; if (id_inst_addr !== 64'd0) begin errors++; $display("FAIL rst_id_inst_addr: got %h want 0", id_inst_addr); end
    @(negedge clk);
    rst = 1'b0; #1;
    checks++; if (if_req !== 1'b0) begin errors++; $display("FAIL idle_if_req: got %b want 0", if_req); end
    @(negedge clk); #1;
    checks++; if (if_req !== 1'b1) begin errors++; $display("FAIL req_if_req: got %b want 1", if_req); end
  endtask

  task automatic test_first_fetch;
    do_reset;
    if_ready = 1'b1; #1;
    checks++; if (if_addr !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL ff_addr0: got %h want 80000000", if_addr); end
    @(negedge clk);
    if_rvalid = 1'b1; if_rdata = 32'h0000_0513; #1;
    checks++; if (if_req !== 1'b0) begin errors++; $display("FAIL ff_wait_req: got %b want 0", if_req); end
    @(negedge clk);
    if_rvalid = 1'b0; #1;
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL ff_valid: got %b want 1", id_valid); end
    checks++; if (id_inst !== 32'h0000_0513) begin errors++; $display("FAIL ff_inst: got %h want 00000513", id_inst); end
    checks++; if (id_inst_addr !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL ff_inst_addr: got %h want 80000000", id_inst_addr); end
    checks++; if (if_addr !== 64'h0000_0000_8000_0004) begin errors++; $display("FAIL ff_next_addr: got %h want 80000004", if_addr); end
  endtask

  task automatic test_backpressure;
    do_reset;
    if_ready = 1'b1;
    fetch_one(32'hAAAA_0001);
    for (int i = 0; i < 3; i++) begin
      step; #1;
      checks++; if (if_req !== 1'b0) begin errors++; $display("FAIL bp_hold_req[%0d]: got %b want 0", i, if_req); end
      checks++; if (id_valid !== 1'b1 || id_inst !== 32'hAAAA_0001) begin errors++; $display("FAIL bp_hold_buf[%0d]: got %b/%h want 1/aaaa0001", i, id_valid, id_inst); end
    end
    id_ready = 1'b1; #1;
    checks++; if (if_req !== 1'b1 || if_addr !== 64'h0000_0000_8000_0004) begin errors++; $display("FAIL bp_release: got %b/%h want 1/80000004", if_req, if_addr); end
    step;
    id_ready = 1'b0; #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b want 0", id_valid); end
    checks++; if (if_req !== 1'b0) begin errors++; $display("FAIL bp_one_outstanding: got %b want 0", if_req); end
    if_rvalid = 1'b1; if_rdata = 32'hAAAA_0002;
    step;
    if_rvalid = 1'b0; #1;
    checks++; if (id_inst !== 32'hAAAA_0002 || id_inst_addr !== 64'h0000_0000_8000_0004) begin errors++; $display("FAIL bp_second: got %h@%h want aaaa0002@80000004", id_inst, id_inst_addr); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] exp_addr;
    do_reset;
    if_ready = 1'b1; id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_one(32'h0000_1000 + 32'(i)); #1;
      exp_addr = 64'h0000_0000_8000_0000 + 64'(4 * i);
      checks++; if (id_valid !== 1'b1 || id_inst !== 32'h0000_1000 + 32'(i) || id_inst_addr !== exp_addr) begin
        errors++; $display("FAIL b2b[%0d]: got %b %h@%h want 1 %h@%h", i, id_valid, id_inst, id_inst_addr, 32'h0000_1000 + 32'(i), exp_addr);
      end
    end
  endtask

  task automatic test_jump_wait;
    do_reset;
    if_ready = 1'b1;
    step;
    jmp_en = 1'b1; jmp_addr = 64'h0000_0000_8000_0103;
    step;
    jmp_en = 1'b0; if_rvalid = 1'b1; if_rdata = 32'hDEAD_BEEF; #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL jw_flush: got %b want 0", id_valid); end
    step;
    if_rvalid = 1'b0; #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL jw_drop: got %b want 0", id_valid); end
    checks++; if (if_req !== 1'b1 || if_addr !== 64'h0000_0000_8000_0100) begin errors++; $display("FAIL jw_target: got %b/%h want 1/80000100", if_req, if_addr); end
    fetch_one(32'h2222_2222); #1;
    checks++; if (id_valid !== 1'b1 || id_inst !== 32'h2222_2222 || id_inst_addr !== 64'h0000_0000_8000_0100) begin errors++; $display("FAIL jw_refetch: got %b %h@%h want 1 22222222@80000100", id_valid, id_inst, id_inst_addr); end
  endtask

  task automatic test_jump_rvalid;
    do_reset;
    if_ready = 1'b1;
    step;
    if_rvalid = 1'b1; if_rdata = 32'h3333_3333; jmp_en = 1'b1; jmp_addr = 64'h0000_0000_0000_1000;
    step;
    if_rvalid = 1'b0; jmp_en = 1'b0; #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL jr_drop: got %b want 0", id_valid); end
    checks++; if (if_req !== 1'b1 || if_addr !== 64'h0000_0000_0000_1000) begin errors++; $display("FAIL jr_target: got %b/%h want 1/1000", if_req, if_addr); end
    fetch_one(32'h4444_4444); #1;
    checks++; if (id_valid !== 1'b1 || id_inst !== 32'h4444_4444 || id_inst_addr !== 64'h0000_0000_0000_1000) begin errors++; $display("FAIL jr_no_kill: got %b %h@%h want 1 44444444@1000", id_valid, id_inst, id_inst_addr); end
  endtask

  task automatic test_jump_req;
    do_reset;
    if_ready = 1'b1;
    fetch_one(32'h5555_0000);
    id_ready = 1'b1; jmp_en = 1'b1; jmp_addr = 64'h0000_0000_0000_2000; if_ready = 1'b0;
    step;
    jmp_en = 1'b0; id_ready = 1'b0; #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL jq_xfer_flush: got %b want 0", id_valid); end
    checks++; if (if_req !== 1'b1 || if_addr !== 64'h0000_0000_0000_2000) begin errors++; $display("FAIL jq_addr_change: got %b/%h want 1/2000", if_req, if_addr); end
    if_ready = 1'b1; jmp_en = 1'b1; jmp_addr = 64'h0000_0000_0000_3000;
    step;
    jmp_en = 1'b0; if_rvalid = 1'b1; if_rdata = 32'h6666_6666;
    step;
    if_rvalid = 1'b0; #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL jq_kill_drop: got %b want 0", id_valid); end
    checks++; if (if_req !== 1'b1 || if_addr !== 64'h0000_0000_0000_3000) begin errors++; $display("FAIL jq_kill_target: got %b/%h want 1/3000", if_req, if_addr); end
    fetch_one(32'h7777_7777); #1;
    checks++; if (id_valid !== 1'b1 || id_inst !== 32'h7777_7777 || id_inst_addr !== 64'h0000_0000_0000_3000) begin errors++; $display("FAIL jq_refetch: got %b %h@%h want 1 77777777@3000", id_valid, id_inst, id_inst_addr); end
  endtask

  task automatic test_wrap;
    do_reset;
    jmp_en = 1'b1; jmp_addr = 64'hFFFF_FFFF_FFFF_FFFF;
    step;
    jmp_en = 1'b0; #1;
    checks++; if (if_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_align: got %h want fffffffffffffffc", if_addr); end
    if_ready = 1'b1;
    fetch_one(32'h9999_0000);
    if_ready = 1'b0; #1;
    checks++; if (id_inst_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_inst_addr: got %h want fffffffffffffffc", id_inst_addr); end
    checks++; if (if_addr !== 64'd0) begin errors++; $display("FAIL wrap_next: got %h want 0", if_addr); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    if_ready = 1'b1;
    step;
    rst = 1'b1; #1;
    checks++; if (if_req !== 1'b0 || if_addr !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL rm_async: got %b/%h want 0/80000000", if_req, if_addr); end
    step;
    rst = 1'b0; if_rvalid = 1'b1; if_rdata = 32'hBAD0_BAD0; #1;
    checks++; if (if_req !== 1'b0) begin errors++; $display("FAIL rm_idle: got %b want 0", if_req); end
    step;
    if_ready = 1'b0; #1;
    checks++; if (if_req !== 1'b1 || if_addr !== 64'h0000_0000_8000_0000 || id_valid !== 1'b0) begin errors++; $display("FAIL rm_first: got %b/%h/%b want 1/80000000/0", if_req, if_addr, id_valid); end
    step;
    if_rvalid = 1'b0; #1;
    checks++; if (id_valid !== 1'b0 || id_inst !== 32'd0) begin errors++; $display("FAIL rm_stale: got %b/%h want 0/00000000", id_valid, id_inst); end
  endtask

  initial begin
    test_reset;
    test_first_fetch;
    test_backpressure;
    test_back_to_back;
    test_jump_wait;
    test_jump_rvalid;
    test_jump_req;
    test_wrap;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
